// File: rtl/seq_muldiv_alu.sv
// EX-stage ALU: combinational logic/arith/shift ops plus a sequential unsigned
// multiply/divide engine (one iteration per clock) that owns the HI/LO registers.
module seq_muldiv_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SRL   = 4'b0011;
  localparam logic [3:0] OP_MFHI  = 4'b0100;
  localparam logic [3:0] OP_MFLO  = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRA   = 4'b1001;
  localparam logic [3:0] OP_MULTU = 4'b1010;
  localparam logic [3:0] OP_DIVU  = 4'b1011;

  localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
  logic             is_div;
  logic [SHW-1:0]   cnt;
  logic             launch, last_iter;

  // Multiply: acc_lo holds the multiplier and fills with product bits from the top.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi, mul_lo;
  // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in.
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_hi, div_lo;
  logic [WIDTH-1:0] iter_hi, iter_lo;

  assign launch    = start && (op == OP_MULTU || op == OP_DIVU) && (state != RUN);
  assign last_iter = (cnt == LAST_ITER);

  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
  assign mul_hi  = mul_sum[WIDTH:1];
  assign mul_lo  = {mul_sum[0], acc_lo[WIDTH-1:1]};

  // A zero divisor always "fits", giving quotient all ones and remainder = dividend.
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd});
  assign div_hi    = div_ge ? WIDTH'(div_shift - {1'b0, opnd}) : div_shift[WIDTH-1:0];
  assign div_lo    = {acc_lo[WIDTH-2:0], div_ge};

  assign iter_hi = is_div ? div_hi : mul_hi;
  assign iter_lo = is_div ? div_lo : mul_lo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (launch) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_iter) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = launch ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_hi      <= '0;
      acc_lo      <= '0;
      opnd        <= '0;
      is_div      <= 1'b0;
      cnt         <= '0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else if (launch) begin
      is_div      <= (op == OP_DIVU);
      opnd        <= (op == OP_DIVU) ? b : a;
      acc_lo      <= (op == OP_DIVU) ? a : b;
      acc_hi      <= '0;
      cnt         <= '0;
      div_by_zero <= 1'b0;
    end else if (state == RUN) begin
      acc_hi <= iter_hi;
      acc_lo <= iter_lo;
      cnt    <= cnt + 1'b1;
      if (last_iter) begin
        hi          <= iter_hi;
        lo          <= iter_lo;
        div_by_zero <= is_div && (opnd == '0);
      end
    end
  end

  always_comb begin
    result = '0;
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_SLT:  result = WIDTH'($signed(a) < $signed(b));
      OP_SRL:  result = b >> shamt;
      OP_SLL:  result = b << shamt;
      OP_SRA:  result = $signed(b) >>> shamt;
      OP_MFHI: result = hi;
      OP_MFLO: result = lo;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: tb/tb_seq_muldiv_alu.sv
// Directed bench for seq_muldiv_alu with a scoreboard queue of expected results.
module tb_seq_muldiv_alu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   op = 4'b0000;
  logic [W-1:0] a = '0, b = '0;
  logic [4:0]   shamt = '0;
  logic [W-1:0] result, hi, lo;
  logic         zero, busy, done, div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;
  logic [2*W:0] sb_q[$];

  seq_muldiv_alu #(.WIDTH(W), .SHW(5)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .shamt(shamt),
    .result(result), .zero(zero), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2*W:0] obs, input logic [2*W:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic comb_op(input string tag, input logic [3:0] o, input logic [W-1:0] va,
                         input logic [W-1:0] vb, input logic [4:0] sh, input logic [W-1:0] exp);
    logic [2*W:0] e;
    op = o; a = va; b = vb; shamt = sh;
    sb_q.push_back({{(W+1){1'b0}}, exp});
    #1;
    e = sb_q.pop_front();
    chk(tag, {{(W+1){1'b0}}, result}, e);
  endtask

  // Launches a multi-cycle op; optionally retries start mid-run, which must be ignored.
  task automatic run_md(input string tag, input logic [3:0] o, input logic [W-1:0] va,
                        input logic [W-1:0] vb, input logic [W-1:0] eh, input logic [W-1:0] el,
                        input logic edz, input bit intrude);
    int edges;
    logic [2*W:0] e;
    @(posedge clk); #1;
    op = o; a = va; b = vb; start = 1'b1;
    sb_q.push_back({edz, eh, el});
    @(posedge clk); #1;
    start = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'h5;
    chk({tag, " busy after launch"}, {64'd0, busy}, 65'd1);
    edges = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      edges++;
      if (intrude && edges == 5) begin op = 4'b1010; start = 1'b1; end
      if (intrude && edges == 6) start = 1'b0;
      if (done) break;
    end
    chk({tag, " latency"}, 65'(edges), 65'd32);
    chk({tag, " busy at done"}, {64'd0, busy}, 65'd0);
    e = sb_q.pop_front();
    chk({tag, " dbz/hi/lo"}, {div_by_zero, hi, lo}, e);
  endtask

  initial begin
    int seen_done;
    #2;
    chk("reset hi/lo", {1'b0, hi, lo}, 65'd0);
    chk("reset busy/done/dbz", {62'd0, busy, done, div_by_zero}, 65'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    comb_op("ADD wrap", 4'b0010, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000);
    chk("ADD zero", {64'd0, zero}, 65'd0);
    comb_op("SUB 5-5", 4'b0110, 32'd5, 32'd5, 5'd0, 32'd0);
    chk("SUB zero", {64'd0, zero}, 65'd1);
    comb_op("SLT -1<1", 4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1);
    comb_op("SLT ovf", 4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, 5'd0, 32'd0);
    comb_op("SRA", 4'b1001, 32'd0, 32'h8000_0000, 5'd4, 32'hF800_0000);
    comb_op("SRL", 4'b0011, 32'd0, 32'h8000_0000, 5'd4, 32'h0800_0000);
    comb_op("SLL", 4'b1000, 32'd0, 32'd1, 5'd31, 32'h8000_0000);
    comb_op("AND", 4'b0000, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0, 32'h00F0_000F);
    comb_op("OR", 4'b0001, 32'hF000_0001, 32'h0000_0F00, 5'd0, 32'hF000_0F01);
    comb_op("undef op", 4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'd0);

    run_md("MULTU max", 4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0, 1'b0);
    run_md("DIVU 100/7", 4'b1011, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0);
    comb_op("MFLO", 4'b0101, 32'd0, 32'd0, 5'd0, 32'd14);
    comb_op("MFHI", 4'b0100, 32'd0, 32'd0, 5'd0, 32'd2);
    run_md("DIVU by 0", 4'b1011, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF, 1'b1, 1'b1);
    comb_op("MULTU result", 4'b1010, 32'd3, 32'd4, 5'd0, 32'd0);

    // Reset during a MULTU: pre-op HI visible mid-run, then abort with no done pulse.
    @(posedge clk); #1;
    op = 4'b1010; a = 32'hFFFF_FFFF; b = 32'h2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    comb_op("MFHI during run", 4'b0100, 32'd0, 32'd0, 5'd0, 32'h1234);
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort busy", {64'd0, busy}, 65'd0);
    chk("abort hi/lo", {1'b0, hi, lo}, 65'd0);
    chk("abort dbz", {64'd0, div_by_zero}, 65'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 35; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen_done++;
    end
    chk("no done after abort", 65'(seen_done), 65'd0);

    run_md("DIVU 9/3", 4'b1011, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
